// File: rtl/nibble_add_scheduler.sv
// Two-requester wide adder that time-shares one 4-bit adder slice, one nibble per cycle,
// LSB nibble first, with round-robin arbitration and a single tagged response channel.
module nibble_add_scheduler #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [4*WORDS-1:0]   req0_a,
    input  logic [4*WORDS-1:0]   req0_b,
    input  logic                 req0_cin,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [4*WORDS-1:0]   req1_a,
    input  logic [4*WORDS-1:0]   req1_b,
    input  logic                 req1_cin,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [4*WORDS-1:0]   rsp_sum,
    output logic                 rsp_cout,
    output logic                 rsp_id,
    output logic                 busy
);

    localparam int W   = 4 * WORDS;
    localparam int K_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t         state;
    state_t         state_next;
    logic [K_W-1:0] k;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   sum_q;
    logic           carry_q;
    logic           id_q;
    logic           last_grant;

    logic           grant_sel;
    logic           accept;
    logic [3:0]     a_nib;
    logic [3:0]     b_nib;
    logic [3:0]     s_nib;
    logic           c_nib;

    // Round-robin: on a tie the requester that did not win last time is chosen.
    always_comb begin
        grant_sel = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        accept    = (state == IDLE) && rst_n && (req0_valid || req1_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ADD;
            ADD:     if (k == K_LAST) state_next = DONE;
            DONE:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = accept && !grant_sel;
        req1_ready = accept && grant_sel;
        rsp_valid  = (state == DONE);
        busy       = (state != IDLE);
        rsp_sum    = sum_q;
        rsp_cout   = carry_q;
        rsp_id     = id_q;
    end

    // The single shared 4-bit slice, fed by the nibble selected by k.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (k == K_W'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
        {c_nib, s_nib} = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            carry_q    <= 1'b0;
            id_q       <= 1'b0;
            last_grant <= 1'b1;
            k          <= '0;
        end else if (accept) begin
            a_q        <= grant_sel ? req1_a : req0_a;
            b_q        <= grant_sel ? req1_b : req0_b;
            carry_q    <= grant_sel ? req1_cin : req0_cin;
            id_q       <= grant_sel;
            last_grant <= grant_sel;
            k          <= '0;
        end else if (state == ADD) begin
            carry_q <= c_nib;
            for (int i = 0; i < WORDS; i++) begin
                if (k == K_W'(i)) begin
                    sum_q[4*i +: 4] <= s_nib;
                end
            end
            k <= (k == K_LAST) ? '0 : k + K_W'(1);
        end
    end

endmodule

// File: tb/tb_nibble_add_scheduler.sv
// Scoreboard bench for nibble_add_scheduler: a WORDS=4 instance for most scenarios
// and a WORDS=1 instance for the single-nibble case.
module tb_nibble_add_scheduler;

    typedef struct packed {
        logic        id;
        logic [15:0] sum;
        logic        cout;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_cin = 1'b0, req1_cin = 1'b0;
    logic        rsp_valid, rsp_cout, rsp_id, busy;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_sum;

    logic        d1_req0_valid = 1'b0, d1_req1_valid = 1'b0;
    logic        d1_req0_ready, d1_req1_ready;
    logic [3:0]  d1_req0_a = '0, d1_req0_b = '0, d1_req1_a = '0, d1_req1_b = '0;
    logic        d1_req0_cin = 1'b0, d1_req1_cin = 1'b0;
    logic        d1_rsp_valid, d1_rsp_cout, d1_rsp_id, d1_busy;
    logic        d1_rsp_ready = 1'b1;
    logic [3:0]  d1_rsp_sum;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    nibble_add_scheduler #(.WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .rsp_id(rsp_id), .busy(busy)
    );

    nibble_add_scheduler #(.WORDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(d1_req0_valid), .req0_ready(d1_req0_ready), .req0_a(d1_req0_a), .req0_b(d1_req0_b),
        .req0_cin(d1_req0_cin),
        .req1_valid(d1_req1_valid), .req1_ready(d1_req1_ready), .req1_a(d1_req1_a), .req1_b(d1_req1_b),
        .req1_cin(d1_req1_cin),
        .rsp_valid(d1_rsp_valid), .rsp_ready(d1_rsp_ready), .rsp_sum(d1_rsp_sum), .rsp_cout(d1_rsp_cout),
        .rsp_id(d1_rsp_id), .busy(d1_busy)
    );

    function automatic exp_t model(input logic id, input logic [15:0] a, input logic [15:0] b, input logic cin);
        logic [16:0] t;
        t = {1'b0, a} + {1'b0, b} + {16'b0, cin};
        model.id   = id;
        model.sum  = t[15:0];
        model.cout = t[16];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        tick();
        tick();
        total++;
        if ({req0_ready, req1_ready, rsp_valid, busy, rsp_cout, rsp_id} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {req0_ready, req1_ready, rsp_valid, busy, rsp_cout, rsp_id});
        end
        total++;
        if (rsp_sum !== 16'h0000) begin
            bad++;
            $display("FAIL reset_sum: got %h expected 0000", rsp_sum);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        total++;
        if ({req0_ready, req1_ready, rsp_valid, busy, d1_busy} !== 5'b0) begin
            bad++;
            $display("FAIL reset_idle: got %b expected 00000", {req0_ready, req1_ready, rsp_valid, busy, d1_busy});
        end
    endtask

    task automatic test_req0_single();
        exp_t e;
        rsp_ready = 1'b1;
        req0_a = 16'h00FF; req0_b = 16'h0001; req0_cin = 1'b0; req0_valid = 1'b1;
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++;
            $display("FAIL r0_grant: got %b expected 10", {req0_ready, req1_ready});
        end
        sbq.push_back(model(1'b0, req0_a, req0_b, req0_cin));
        tick();
        req0_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            total++;
            if (rsp_valid !== (i == 4)) begin
                bad++;
                $display("FAIL r0_latency: cycle %0d rsp_valid got %b expected %b", i, rsp_valid, (i == 4));
            end
        end
        e = sbq.pop_front();
        total++;
        if ({rsp_id, rsp_sum, rsp_cout} !== {e.id, e.sum, e.cout} || e.sum !== 16'h0100) begin
            bad++;
            $display("FAIL r0_result: got id=%b sum=%h cout=%b expected id=%b sum=%h cout=%b",
                     rsp_id, rsp_sum, rsp_cout, e.id, e.sum, e.cout);
        end
        tick();
        total++;
        if ({rsp_valid, busy} !== 2'b00) begin
            bad++;
            $display("FAIL r0_release: got %b expected 00", {rsp_valid, busy});
        end
    endtask

    task automatic test_carry_ripple();
        exp_t e;
        bit   seen = 0;
        req1_a = 16'hFFFF; req1_b = 16'h0000; req1_cin = 1'b1; req1_valid = 1'b1;
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            bad++;
            $display("FAIL ripple_grant: got %b expected 01", {req0_ready, req1_ready});
        end
        sbq.push_back(model(1'b1, req1_a, req1_b, req1_cin));
        tick();
        req1_valid = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (rsp_valid) begin
                seen = 1;
                e = sbq.pop_front();
                total++;
                if ({rsp_id, rsp_sum, rsp_cout} !== {e.id, e.sum, e.cout}) begin
                    bad++;
                    $display("FAIL ripple_result: got id=%b sum=%h cout=%b expected id=%b sum=%h cout=%b",
                             rsp_id, rsp_sum, rsp_cout, e.id, e.sum, e.cout);
                end
            end
            tick();
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL ripple_timeout: got no response expected one");
            sbq.delete();
        end
    endtask

    task automatic test_words1();
        logic [4:0] t;
        d1_req0_a = 4'hB; d1_req0_b = 4'hE; d1_req0_cin = 1'b0; d1_req0_valid = 1'b1;
        t = {1'b0, d1_req0_a} + {1'b0, d1_req0_b} + {4'b0, d1_req0_cin};
        #1;
        total++;
        if (d1_req0_ready !== 1'b1) begin
            bad++;
            $display("FAIL w1_grant: got %b expected 1", d1_req0_ready);
        end
        tick();
        d1_req0_valid = 1'b0;
        total++;
        if (d1_rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL w1_early: rsp_valid got %b expected 0", d1_rsp_valid);
        end
        tick();
        total++;
        if ({d1_rsp_valid, d1_rsp_id, d1_rsp_sum, d1_rsp_cout} !== {1'b1, 1'b0, t[3:0], t[4]}) begin
            bad++;
            $display("FAIL w1_result: got v=%b id=%b sum=%h cout=%b expected v=1 id=0 sum=%h cout=%b",
                     d1_rsp_valid, d1_rsp_id, d1_rsp_sum, d1_rsp_cout, t[3:0], t[4]);
        end
        tick();
    endtask

    task automatic test_contention();
        exp_t e;
        int   ng = 0;
        int   both_hi = 0;
        int   gid[4];
        int   gcyc[4];
        bit   took0, took1;
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        req0_a = 16'h1234; req0_b = 16'h4321; req0_cin = 1'b0;
        req1_a = 16'h8FFF; req1_b = 16'h7001; req1_cin = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        tick();
        rst_n = 1'b1;
        #1;
        for (int c = 0; c < 100 && ng < 4; c++) begin
            took0 = 0; took1 = 0;
            if (req0_ready && req1_ready) both_hi++;
            if (rsp_valid) begin
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL cont_extra_rsp: got id=%b expected no response", rsp_id);
                end else begin
                    e = sbq.pop_front();
                    total++;
                    if ({rsp_id, rsp_sum, rsp_cout} !== {e.id, e.sum, e.cout}) begin
                        bad++;
                        $display("FAIL cont_result: got id=%b sum=%h cout=%b expected id=%b sum=%h cout=%b",
                                 rsp_id, rsp_sum, rsp_cout, e.id, e.sum, e.cout);
                    end
                end
            end
            if (req0_ready) begin
                sbq.push_back(model(1'b0, req0_a, req0_b, req0_cin));
                gid[ng] = 0; gcyc[ng] = cyc; ng++; took0 = 1;
            end else if (req1_ready) begin
                sbq.push_back(model(1'b1, req1_a, req1_b, req1_cin));
                gid[ng] = 1; gcyc[ng] = cyc; ng++; took1 = 1;
            end
            tick();
            if (took0) begin
                req0_a = 16'($urandom); req0_b = 16'($urandom); req0_cin = 1'($urandom);
            end
            if (took1) begin
                req1_a = 16'($urandom); req1_b = 16'($urandom); req1_cin = 1'($urandom);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        total++;
        if (ng !== 4) begin
            bad++;
            $display("FAIL cont_grants: got %0d grants expected 4", ng);
        end
        for (int i = 0; i < ng; i++) begin
            total++;
            if (gid[i] !== (i % 2)) begin
                bad++;
                $display("FAIL cont_order: grant %0d got id %0d expected %0d", i, gid[i], i % 2);
            end
            if (i > 0) begin
                total++;
                if (gcyc[i] - gcyc[i-1] !== 6) begin
                    bad++;
                    $display("FAIL cont_interval: grant %0d got %0d cycles expected 6", i, gcyc[i] - gcyc[i-1]);
                end
            end
        end
        total++;
        if (both_hi !== 0) begin
            bad++;
            $display("FAIL cont_onehot: got %0d cycles with both ready expected 0", both_hi);
        end
        for (int c = 0; c < 20 && sbq.size() > 0; c++) begin
            if (rsp_valid) begin
                e = sbq.pop_front();
                total++;
                if ({rsp_id, rsp_sum, rsp_cout} !== {e.id, e.sum, e.cout}) begin
                    bad++;
                    $display("FAIL cont_drain: got id=%b sum=%h cout=%b expected id=%b sum=%h cout=%b",
                             rsp_id, rsp_sum, rsp_cout, e.id, e.sum, e.cout);
                end
            end
            tick();
        end
        if (sbq.size() != 0) begin
            total++; bad++;
            $display("FAIL cont_timeout: got %0d pending expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_backpressure();
        exp_t        e;
        logic [17:0] held;
        bit          seen = 0;
        rsp_ready = 1'b0;
        req0_a = 16'hA5A5; req0_b = 16'h5A5B; req0_cin = 1'b1; req0_valid = 1'b1;
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++;
            $display("FAIL bp_grant: got %b expected 10", {req0_ready, req1_ready});
        end
        sbq.push_back(model(1'b0, req0_a, req0_b, req0_cin));
        tick();
        req0_valid = 1'b0;
        req1_a = 16'h0F0F; req1_b = 16'hF0F1; req1_cin = 1'b0; req1_valid = 1'b1;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (rsp_valid) seen = 1;
            else tick();
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL bp_timeout: got no response expected one");
            $fatal(1, "no response under backpressure");
        end
        held = {rsp_id, rsp_sum, rsp_cout};
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({rsp_valid, busy, req0_ready, req1_ready, rsp_id, rsp_sum, rsp_cout} !== {4'b1100, held}) begin
                bad++;
                $display("FAIL bp_hold: cycle %0d got v=%b busy=%b rdy=%b%b rsp=%h expected v=1 busy=1 rdy=00 rsp=%h",
                         i, rsp_valid, busy, req0_ready, req1_ready, {rsp_id, rsp_sum, rsp_cout}, held);
            end
        end
        e = sbq.pop_front();
        total++;
        if (held !== {e.id, e.sum, e.cout}) begin
            bad++;
            $display("FAIL bp_result: got %h expected %h", held, {e.id, e.sum, e.cout});
        end
        rsp_ready = 1'b1;
        tick();
        total++;
        if ({rsp_valid, req0_ready, req1_ready} !== 3'b001) begin
            bad++;
            $display("FAIL bp_release: got v=%b rdy=%b%b expected v=0 rdy=01", rsp_valid, req0_ready, req1_ready);
        end
        sbq.push_back(model(1'b1, req1_a, req1_b, req1_cin));
        tick();
        req1_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (rsp_valid) begin
                seen = 1;
                e = sbq.pop_front();
                total++;
                if ({rsp_id, rsp_sum, rsp_cout} !== {e.id, e.sum, e.cout}) begin
                    bad++;
                    $display("FAIL bp_next: got id=%b sum=%h cout=%b expected id=%b sum=%h cout=%b",
                             rsp_id, rsp_sum, rsp_cout, e.id, e.sum, e.cout);
                end
            end
            tick();
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL bp_next_timeout: got no response expected one");
            sbq.delete();
        end
    endtask

    task automatic test_reset_mid_add();
        exp_t e;
        bit   seen = 0;
        rsp_ready = 1'b1;
        req1_a = 16'h1111; req1_b = 16'h1111; req1_cin = 1'b0; req1_valid = 1'b1;
        #1;
        total++;
        if (req1_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_grant: got %b expected 1", req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_a = 16'h7FFF; req0_b = 16'h0001; req0_cin = 1'b0;
        #1;
        total++;
        if ({busy, rsp_valid, req0_ready, req1_ready, rsp_id, rsp_cout, rsp_sum} !== 22'b0) begin
            bad++;
            $display("FAIL mid_reset: got busy=%b v=%b rdy=%b%b id=%b cout=%b sum=%h expected all 0",
                     busy, rsp_valid, req0_ready, req1_ready, rsp_id, rsp_cout, rsp_sum);
        end
        tick();
        rst_n = 1'b1;
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++;
            $display("FAIL mid_first_grant: got %b expected 10", {req0_ready, req1_ready});
        end
        sbq.push_back(model(1'b0, req0_a, req0_b, req0_cin));
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (rsp_valid) begin
                seen = 1;
                e = sbq.pop_front();
                total++;
                if ({rsp_id, rsp_sum, rsp_cout} !== {e.id, e.sum, e.cout}) begin
                    bad++;
                    $display("FAIL mid_result: got id=%b sum=%h cout=%b expected id=%b sum=%h cout=%b",
                             rsp_id, rsp_sum, rsp_cout, e.id, e.sum, e.cout);
                end
            end
            tick();
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL mid_timeout: got no response expected one");
        end
    endtask

    initial begin
        test_reset();
        test_req0_single();
        test_carry_ripple();
        test_words1();
        test_contention();
        test_backpressure();
        test_reset_mid_add();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nibble_add_scheduler.md
# nibble_add_scheduler

Multi-cycle adder controller that shares one 4-bit ripple-carry adder slice between two requesters. It accepts wide operands over a valid/ready handshake, with round-robin arbitration between the two requesters. The wide addition runs one nibble per cycle, least significant first, with the carry held in a register between cycles. The result and final carry are returned on a single response channel tagged with the requester id. The block sits between the two operand-producing units and the shared arithmetic resource, so the design needs only one 4-bit adder instance.

## Interface
- WORDS, 4, number of 4-bit nibbles per operand (≥1); operand width W = 4*WORDS
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has operands
- req0_ready  out  1  requester 0 accepted this cycle (transfer when valid && ready)
- req0_a, req0_b  in  W  requester 0 operands
- req0_cin  in  1  requester 0 carry-in
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result (transfer when valid && ready)
- rsp_sum  out  W  (a + b + cin) mod 2^W
- rsp_cout  out  1  carry out of bit W-1
- rsp_id  out  1  requester that issued the operation
- busy  out  1  high in ADD or DONE

## Operation
- The datapath holds one 4-bit full-adder slice. Each ADD cycle it computes {c, s} = a_nib[k] + b_nib[k] + carry_q.
  - s is written to sum_q[4k+3:4k] and c to carry_q.
- The FSM has three states: IDLE, ADD, DONE.
  - IDLE: if any reqN_valid, grant one requester; its reqN_ready = 1 combinationally. On that edge, capture a, b, cin into a_q, b_q, carry_q, record rsp_id, set k = 0, go to ADD. If neither requester is valid, stay in IDLE.
  - ADD: process nibble k, then k ← k+1. After nibble WORDS-1, go to DONE. No requester is accepted while in ADD.
  - DONE: rsp_valid = 1, and rsp_sum, rsp_cout, rsp_id come from registers. On rsp_valid && rsp_ready, go to IDLE.
- Arbitration is round-robin using a last_grant register.
  - If only one requester is valid, grant it.
  - If both are valid, grant the one that is not last_grant.
  - last_grant updates on every accept.
  - Reset value of last_grant = 1, so requester 0 wins the first tie.
- At most one reqN_ready is high in any cycle, and only in IDLE. reqN_ready may depend combinationally on reqN_valid.
- Requesters must hold valid and operands stable until accepted. The block never drops a granted request.
- Carry rules:
  - The carry chains across nibbles.
  - rsp_cout is carry_q after the last nibble.
  - The sum wraps modulo 2^W.
  - WORDS = 1 reduces to a single 4-bit add.
- Reset (asynchronous, any state):
  - The FSM goes to IDLE and k = 0.
  - sum_q, a_q, b_q, carry_q are cleared to 0. rsp_id = 0. last_grant = 1.
  - Any in-flight operation is discarded with no response.
  - All outputs read 0 while rst_n = 0.

## Timing
- Reset values: reqN_ready = 0 (unless a requester is valid after reset release), rsp_valid = 0, rsp_sum = 0, rsp_cout = 0, rsp_id = 0, busy = 0.
- Accept edge = E0.
- ADD occupies the cycles after edges E0 … E(WORDS-1).
- rsp_valid rises after edge E(WORDS), i.e. WORDS cycles after acceptance.
- Response hold under backpressure:
  - If rsp_ready is high when rsp_valid rises, the response transfers on the next edge. IDLE is then active and a new grant is possible in that cycle.
  - While rsp_ready = 0, rsp_valid, rsp_sum, rsp_cout, rsp_id hold stable.
- Minimum issue interval = WORDS + 2 cycles per operation. No overlap between operations.
- Simultaneous events:
  - A request arriving in any state other than IDLE waits.
  - Both requests valid in IDLE: round-robin as above.

## Test plan
- WORDS=4, req0 only: a=16'h00FF, b=16'h0001, cin=0 → rsp_sum=16'h0100, rsp_cout=0, rsp_id=0. rsp_valid rises exactly 4 cycles after the accept edge.
- WORDS=4, full carry ripple: req1 a=16'hFFFF, b=16'h0000, cin=1 → rsp_sum=16'h0000, rsp_cout=1, rsp_id=1.
- WORDS=1: a=4'hB, b=4'hE, cin=0 → rsp_sum=4'h9, rsp_cout=1. Response 1 cycle after accept.
- Contention: both requesters held valid from reset release, rsp_ready=1 → grants in order 0, 1, 0, 1. Each grant comes WORDS+2 cycles after the previous one. rsp_id matches each grant and only one reqN_ready is ever high.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE → rsp_* stable, busy=1, no reqN_ready asserted. On release the response transfers once.
- Reset mid-ADD: assert rst_n=0 at nibble k=2 → busy, rsp_valid, and all outputs drop to 0 immediately. After release, with both requesters valid, requester 0 is granted first.
